radio_pll_sequencer: RTL and testbench

- Consumer end of the TimingEngine Stage2 outputs and producer of the Stage1 `pllSettled` input.
- Takes per-lane `radioEnable`/`radioRxEn` and sequences synthesizer power-up, settle wait and lock qualification for each lane.
- Reports `pllSettled` back to the timing engine.
- Sits between the timing engine and the analog PLL control pins, one independent lane per radio bit.

---
 rtl/radio_pll_pkg.sv | 16 +
 rtl/radio_pll_lane.sv | 201 ++++++++++++++++++++
 rtl/radio_pll_sequencer.sv | 40 ++++
 tb/tb_radio_pll_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radio_pll_pkg.sv
// Shared types and default constants for the radio PLL sequencer.
// The lane FAIL state is only reachable when RADIO_PLL_TIMEOUT_EN is defined.
package radio_pll_pkg;

  localparam int DEF_SETTLE_W       = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1023;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWRUP    = 3'd1,
    ST_LOCKWAIT = 3'd2,
    ST_SETTLED  = 3'd3,
    ST_FAIL     = 3'd4
  } lane_state_e;

endpackage

// File: rtl/radio_pll_lane.sv
// One PLL lane: lock synchronizer, settle counter, optional lock timeout
// (RADIO_PLL_TIMEOUT_EN) and a Moore FSM with registered outputs.
module radio_pll_lane
  import radio_pll_pkg::*;
#(
  parameter int SETTLE_W       = DEF_SETTLE_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                radio_enable,
  input  logic                radio_rx_en,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                pll_lock_raw,
  output logic                pll_en,
  output logic                pll_rx_mode,
  output logic                pll_settled,
  output logic                pll_fail
);

  lane_state_e         state_r;
  lane_state_e         next_state_s;
  logic                lock_meta_r;
  logic                lock_sync_r;
  logic [SETTLE_W-1:0] cnt_r;
  logic                rx_cap_r;
  logic                load_s;
  logic                retune_s;
  logic                tmo_hit_s;
  logic                en_s;
  logic                rx_s;
  logic                settled_s;
  logic                fail_s;

`ifdef RADIO_PLL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_r;

  assign tmo_hit_s = (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Consecutive LOCKWAIT cycle counter; any other state clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r <= {TMO_W{1'b0}};
    end else if ((state_r == ST_LOCKWAIT) && (next_state_s == ST_LOCKWAIT)) begin
      tmo_r <= tmo_r + TMO_W'(1);
    end else begin
      tmo_r <= {TMO_W{1'b0}};
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  assign retune_s = (radio_rx_en != rx_cap_r);

  // Two-flop synchronizer for the asynchronous analog lock indicator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_lock_raw;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Lane state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: disable outranks retune, retune outranks lock and timeout events
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (radio_enable) begin
          next_state_s = ST_PWRUP;
          load_s       = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PWRUP: begin
        if (!radio_enable) begin
          next_state_s = ST_IDLE;
        end else if (retune_s) begin
          next_state_s = ST_PWRUP;
          load_s       = 1'b1;
        end else if (cnt_r == {SETTLE_W{1'b0}}) begin
          next_state_s = ST_LOCKWAIT;
        end else begin
          next_state_s = ST_PWRUP;
        end
      end
      ST_LOCKWAIT: begin
        if (!radio_enable) begin
          next_state_s = ST_IDLE;
        end else if (retune_s) begin
          next_state_s = ST_PWRUP;
          load_s       = 1'b1;
        end else if (lock_sync_r) begin
          next_state_s = ST_SETTLED;
        end else if (tmo_hit_s) begin
          next_state_s = ST_FAIL;
        end else begin
          next_state_s = ST_LOCKWAIT;
        end
      end
      ST_SETTLED: begin
        if (!radio_enable) begin
          next_state_s = ST_IDLE;
        end else if (retune_s) begin
          next_state_s = ST_PWRUP;
          load_s       = 1'b1;
        end else if (!lock_sync_r) begin
          next_state_s = ST_LOCKWAIT;
        end else begin
          next_state_s = ST_SETTLED;
        end
      end
      ST_FAIL: begin
        if (!radio_enable) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_FAIL;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Settle counter and captured RX/TX mode; settle_cycles is sampled only on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {SETTLE_W{1'b0}};
      rx_cap_r <= 1'b0;
    end else if (load_s) begin
      cnt_r    <= settle_cycles;
      rx_cap_r <= radio_rx_en;
    end else if ((state_r == ST_PWRUP) && (cnt_r != {SETTLE_W{1'b0}})) begin
      cnt_r    <= cnt_r - SETTLE_W'(1);
      rx_cap_r <= rx_cap_r;
    end else begin
      cnt_r    <= cnt_r;
      rx_cap_r <= rx_cap_r;
    end
  end

  // Moore output decode from the lane state
  always_comb begin
    en_s      = 1'b0;
    rx_s      = 1'b0;
    settled_s = 1'b0;
    fail_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        en_s = 1'b0;
      end
      ST_PWRUP, ST_LOCKWAIT: begin
        en_s = 1'b1;
        rx_s = rx_cap_r;
      end
      ST_SETTLED: begin
        en_s      = 1'b1;
        rx_s      = rx_cap_r;
        settled_s = 1'b1;
      end
      ST_FAIL: begin
        fail_s = 1'b1;
      end
      default: begin
        en_s = 1'b0;
      end
    endcase
  end

  // Output registers; without the timeout feature FAIL is unreachable so pll_fail stays 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_en      <= 1'b0;
      pll_rx_mode <= 1'b0;
      pll_settled <= 1'b0;
      pll_fail    <= 1'b0;
    end else begin
      pll_en      <= en_s;
      pll_rx_mode <= rx_s;
      pll_settled <= settled_s;
      pll_fail    <= fail_s;
    end
  end

endmodule

// File: rtl/radio_pll_sequencer.sv
// Top: BIT_WIDTH independent PLL power-up/lock sequencing lanes.
// Optional lock timeout is enabled by defining RADIO_PLL_TIMEOUT_EN.
module radio_pll_sequencer
  import radio_pll_pkg::*;
#(
  parameter int BIT_WIDTH      = 2,
  parameter int SETTLE_W       = DEF_SETTLE_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] radioEnable,
  input  logic [BIT_WIDTH-1:0] radioRxEn,
  input  logic [SETTLE_W-1:0]  settleCycles,
  input  logic [BIT_WIDTH-1:0] pllLockRaw,
  output logic [BIT_WIDTH-1:0] pllEn,
  output logic [BIT_WIDTH-1:0] pllRxMode,
  output logic [BIT_WIDTH-1:0] pllSettled,
  output logic [BIT_WIDTH-1:0] pllFail
);

  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_lane
    radio_pll_lane #(
      .SETTLE_W       (SETTLE_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_lane (
      .clk           (clk),
      .rst_n         (rst_n),
      .radio_enable  (radioEnable[i]),
      .radio_rx_en   (radioRxEn[i]),
      .settle_cycles (settleCycles),
      .pll_lock_raw  (pllLockRaw[i]),
      .pll_en        (pllEn[i]),
      .pll_rx_mode   (pllRxMode[i]),
      .pll_settled   (pllSettled[i]),
      .pll_fail      (pllFail[i])
    );
  end

endmodule

// File: tb/tb_radio_pll_sequencer.sv
// Self-checking bench for radio_pll_sequencer: directed scenarios plus random
// stimulus against a cycle-level behavioural model of each lane.
module tb_radio_pll_sequencer;
  localparam int BW  = 2;
  localparam int SW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] radioEnable = '0;
  logic [BW-1:0] radioRxEn = '0;
  logic [BW-1:0] pllLockRaw = '0;
  logic [SW-1:0] settleCycles = '0;
  logic [BW-1:0] pllEn, pllRxMode, pllSettled, pllFail;

  int errors = 0;
  int checks = 0;

  // Model: lane powered, remaining power-up cycles, settled/failed flags, captured mode
  bit m_active[BW];
  bit m_set[BW];
  bit m_fail[BW];
  bit m_rx[BW];
  int m_wait[BW];
  int m_lw[BW];
  bit m_s1[BW];
  bit m_s2[BW];
  logic [BW-1:0] x_en, x_rx, x_set, x_fail;

  always #5 clk = ~clk;

  radio_pll_sequencer #(.BIT_WIDTH(BW), .SETTLE_W(SW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .radioEnable(radioEnable), .radioRxEn(radioRxEn),
    .settleCycles(settleCycles), .pllLockRaw(pllLockRaw), .pllEn(pllEn),
    .pllRxMode(pllRxMode), .pllSettled(pllSettled), .pllFail(pllFail)
  );

  task automatic model_reset();
    for (int i = 0; i < BW; i++) begin
      m_active[i] = 1'b0; m_set[i] = 1'b0; m_fail[i] = 1'b0; m_rx[i] = 1'b0;
      m_wait[i] = 0; m_lw[i] = 0; m_s1[i] = 1'b0; m_s2[i] = 1'b0;
    end
    x_en = '0; x_rx = '0; x_set = '0; x_fail = '0;
  endtask

  // One clock edge: outputs lag the lane status by one register stage
  task automatic tick();
    bit lock;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < BW; i++) begin
        x_en[i]   = m_active[i];
        x_rx[i]   = m_active[i] & m_rx[i];
        x_set[i]  = m_set[i];
        x_fail[i] = m_fail[i];
        lock = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = pllLockRaw[i];
        if (!radioEnable[i]) begin
          m_active[i] = 1'b0; m_set[i] = 1'b0; m_fail[i] = 1'b0;
        end else if (m_fail[i]) begin
          m_fail[i] = 1'b1;
        end else if (!m_active[i] || (radioRxEn[i] != m_rx[i])) begin
          m_active[i] = 1'b1; m_wait[i] = int'(settleCycles) + 1;
          m_rx[i] = radioRxEn[i]; m_set[i] = 1'b0; m_lw[i] = 0;
        end else if (m_wait[i] > 0) begin
          m_wait[i]--;
        end else if (m_set[i]) begin
          if (!lock) begin m_set[i] = 1'b0; m_lw[i] = 0; end
        end else if (lock) begin
          m_set[i] = 1'b1;
        end else begin
`ifdef RADIO_PLL_TIMEOUT_EN
          m_lw[i]++;
          if (m_lw[i] >= TMO) begin m_fail[i] = 1'b1; m_active[i] = 1'b0; end
`endif
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; radioEnable = '0; radioRxEn = '0; pllLockRaw = '0; settleCycles = '0;
    model_reset();
    #12;
    checks++;
    if ({pllEn, pllRxMode, pllSettled, pllFail} !== 8'h00)
      begin errors++; $display("FAIL reset_outputs got=%b exp=%b", {pllEn, pllRxMode, pllSettled, pllFail}, 8'h00); end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({pllEn, pllRxMode, pllSettled, pllFail} !== {x_en, x_rx, x_set, x_fail})
        begin errors++; $display("FAIL reset_idle c=%0d got=%b exp=%b", c, {pllEn, pllRxMode, pllSettled, pllFail}, {x_en, x_rx, x_set, x_fail}); end
    end
  endtask

  task automatic test_basic_powerup();
    pllLockRaw = 2'b11; settleCycles = 8'd4;
    repeat (3) tick();
    radioEnable = 2'b01;
    for (int c = 0; c <= 9; c++) begin
      tick();
      checks++;
      if ({pllEn, pllRxMode, pllSettled, pllFail} !== {x_en, x_rx, x_set, x_fail})
        begin errors++; $display("FAIL basic_model c=%0d got=%b exp=%b", c, {pllEn, pllRxMode, pllSettled, pllFail}, {x_en, x_rx, x_set, x_fail}); end
      checks++;
      if ({pllEn[1], pllRxMode[1], pllSettled[1], pllFail[1]} !== 4'b0000)
        begin errors++; $display("FAIL basic_lane1_idle c=%0d got=%b exp=0000", c, {pllEn[1], pllRxMode[1], pllSettled[1], pllFail[1]}); end
      if (c == 1) begin
        checks++;
        if (pllEn[0] !== 1'b1) begin errors++; $display("FAIL basic_en_c1 got=%b exp=1", pllEn[0]); end
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (pllSettled[0] !== (c == 7)) begin errors++; $display("FAIL basic_settled c=%0d got=%b exp=%b", c, pllSettled[0], c == 7); end
      end
    end
  endtask

  task automatic test_late_lock();
    radioEnable = 2'b00; pllLockRaw = 2'b00;
    repeat (3) tick();
    settleCycles = 8'd2; radioEnable = 2'b01;
    for (int c = 0; c <= 25; c++) begin
      if (c == 20) pllLockRaw = 2'b01;
      tick();
      checks++;
      if ({pllEn, pllRxMode, pllSettled, pllFail} !== {x_en, x_rx, x_set, x_fail})
        begin errors++; $display("FAIL late_model c=%0d got=%b exp=%b", c, {pllEn, pllRxMode, pllSettled, pllFail}, {x_en, x_rx, x_set, x_fail}); end
      if (c == 22 || c == 23) begin
        checks++;
        if (pllSettled[0] !== (c == 23)) begin errors++; $display("FAIL late_settled c=%0d got=%b exp=%b", c, pllSettled[0], c == 23); end
      end
    end
  endtask

  task automatic test_retune();
    radioRxEn = 2'b01;
    for (int c = 0; c <= 7; c++) begin
      tick();
      checks++;
      if ({pllEn, pllRxMode, pllSettled, pllFail} !== {x_en, x_rx, x_set, x_fail})
        begin errors++; $display("FAIL retune_model c=%0d got=%b exp=%b", c, {pllEn, pllRxMode, pllSettled, pllFail}, {x_en, x_rx, x_set, x_fail}); end
      if (c == 1) begin
        checks++;
        if ({pllSettled[0], pllRxMode[0], pllEn[0]} !== 3'b011)
          begin errors++; $display("FAIL retune_drop got=%b exp=011", {pllSettled[0], pllRxMode[0], pllEn[0]}); end
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (pllSettled[0] !== (c == 5)) begin errors++; $display("FAIL retune_resettle c=%0d got=%b exp=%b", c, pllSettled[0], c == 5); end
      end
    end
  endtask

  task automatic test_disable_lockloss();
    radioEnable = 2'b00; radioRxEn = 2'b00; settleCycles = 8'd3; pllLockRaw = 2'b01;
    repeat (2) tick();
    radioEnable = 2'b01;
    for (int c = 0; c <= 5; c++) begin
      if (c == 3) radioEnable = 2'b00;
      tick();
      checks++;
      if ({pllEn, pllRxMode, pllSettled, pllFail} !== {x_en, x_rx, x_set, x_fail})
        begin errors++; $display("FAIL disable_model c=%0d got=%b exp=%b", c, {pllEn, pllRxMode, pllSettled, pllFail}, {x_en, x_rx, x_set, x_fail}); end
      if (c == 3 || c == 4) begin
        checks++;
        if (pllEn[0] !== (c == 3)) begin errors++; $display("FAIL disable_en c=%0d got=%b exp=%b", c, pllEn[0], c == 3); end
      end
    end
    radioEnable = 2'b01;
    repeat (10) tick();
    pllLockRaw = 2'b00;
    for (int c = 0; c <= 5; c++) begin
      tick();
      checks++;
      if ({pllEn, pllRxMode, pllSettled, pllFail} !== {x_en, x_rx, x_set, x_fail})
        begin errors++; $display("FAIL lockloss_model c=%0d got=%b exp=%b", c, {pllEn, pllRxMode, pllSettled, pllFail}, {x_en, x_rx, x_set, x_fail}); end
      if (c == 2 || c == 3) begin
        checks++;
        if ({pllEn[0], pllSettled[0]} !== {1'b1, c == 2})
          begin errors++; $display("FAIL lockloss_settled c=%0d got=%b exp=%b", c, {pllEn[0], pllSettled[0]}, {1'b1, c == 2}); end
      end
    end
  endtask

  task automatic test_reset_boundary();
    radioEnable = 2'b00; pllLockRaw = 2'b11; settleCycles = 8'd5;
    repeat (2) tick();
    radioEnable = 2'b11;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pllEn, pllRxMode, pllSettled, pllFail} !== 8'h00)
      begin errors++; $display("FAIL midrun_reset got=%b exp=%b", {pllEn, pllRxMode, pllSettled, pllFail}, 8'h00); end
    radioEnable = 2'b00; settleCycles = 8'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    radioEnable = 2'b01;
    for (int c = 0; c <= 5; c++) begin
      tick();
      checks++;
      if ({pllEn, pllRxMode, pllSettled, pllFail} !== {x_en, x_rx, x_set, x_fail})
        begin errors++; $display("FAIL zero_model c=%0d got=%b exp=%b", c, {pllEn, pllRxMode, pllSettled, pllFail}, {x_en, x_rx, x_set, x_fail}); end
      if (c == 2 || c == 3) begin
        checks++;
        if (pllSettled[0] !== (c == 3)) begin errors++; $display("FAIL zero_settled c=%0d got=%b exp=%b", c, pllSettled[0], c == 3); end
      end
    end
  endtask

  task automatic test_timeout();
    radioEnable = 2'b00; pllLockRaw = 2'b00; settleCycles = 8'd1;
    repeat (3) tick();
    radioEnable = 2'b11;
    for (int c = 0; c <= 24; c++) begin
      tick();
      checks++;
      if ({pllEn, pllRxMode, pllSettled, pllFail} !== {x_en, x_rx, x_set, x_fail})
        begin errors++; $display("FAIL timeout_model c=%0d got=%b exp=%b", c, {pllEn, pllRxMode, pllSettled, pllFail}, {x_en, x_rx, x_set, x_fail}); end
`ifdef RADIO_PLL_TIMEOUT_EN
      if (c == 18 || c == 19 || c == 24) begin
        checks++;
        if ({pllEn, pllFail} !== ((c == 18) ? 4'b1100 : 4'b0011))
          begin errors++; $display("FAIL timeout_fail c=%0d got=%b exp=%b", c, {pllEn, pllFail}, (c == 18) ? 4'b1100 : 4'b0011); end
      end
`else
      checks++;
      if ({pllFail, pllEn} !== ((c == 0) ? 4'b0000 : 4'b0011))
        begin errors++; $display("FAIL nofail_wait c=%0d got=%b exp=%b", c, {pllFail, pllEn}, (c == 0) ? 4'b0000 : 4'b0011); end
`endif
    end
    radioEnable = 2'b00;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if ({pllEn, pllFail} !== 4'b0000) begin errors++; $display("FAIL timeout_exit got=%b exp=0000", {pllEn, pllFail}); end
      end
    end
  endtask

  task automatic test_random();
    radioEnable = 2'b00; radioRxEn = 2'b00;
    repeat (2) tick();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < BW; i++) begin
        if ($urandom_range(0, 24) == 0) radioEnable[i] = ~radioEnable[i];
        if ($urandom_range(0, 39) == 0) radioRxEn[i] = ~radioRxEn[i];
        if ($urandom_range(0, 9) == 0) pllLockRaw[i] = ~pllLockRaw[i];
      end
      settleCycles = SW'($urandom_range(0, 6));
      tick();
      checks++;
      if ({pllEn, pllRxMode, pllSettled, pllFail} !== {x_en, x_rx, x_set, x_fail})
        begin errors++; $display("FAIL random_model c=%0d got=%b exp=%b", c, {pllEn, pllRxMode, pllSettled, pllFail}, {x_en, x_rx, x_set, x_fail}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_powerup();
    test_late_lock();
    test_retune();
    test_disable_lockloss();
    test_reset_boundary();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
